// File: rtl/uartprobe_rx.sv
// uartprobe_rx: 8N1 UART receiver with a small byte FIFO.
// The pin is double-synchronised. A mid-bit sampling FSM recovers each frame,
// and good bytes are buffered for a valid/ready consumer.
module uartprobe_rx #(
  parameter int CYCLES_PER_BIT = 868,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overflow,
  output logic       rx_busy
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int H  = CYCLES_PER_BIT / 2;
  localparam int AW = $clog2(FIFO_DEPTH);

  // The counter is cleared on the edge where the start bit is seen (k=0).
  // On edge k it therefore holds k-1. This gives a half-bit sample at
  // cnt==H-1 and full-bit samples at cnt==CPB-1 after each re-clear.
  localparam logic [CW-1:0] C_HALF = CW'(H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state, w_nstate;
  logic            r_sync1, r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_frame_err, r_overflow;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr, r_rd;

  logic w_rx_s, w_half, w_last;
  logic w_cnt_clr, w_bit_clr, w_shift_en, w_push, w_ferr;
  logic w_empty, w_full, w_pop, w_wr_en, w_drop;

  assign w_rx_s = r_sync2;
  assign w_half = (r_cnt == C_HALF);
  assign w_last = (r_cnt == C_LAST);

  // Two-flop synchroniser. Both flops reset to idle-high.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_HUNT;
    else          r_state <= w_nstate;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_nstate   = r_state;
    w_cnt_clr  = 1'b0;
    w_bit_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_push     = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      S_HUNT: if (w_rx_s) w_nstate = S_IDLE;
      S_IDLE: begin
        if (!w_rx_s) begin
          w_nstate  = S_START;
          w_cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (w_half) begin
          w_cnt_clr = 1'b1;
          w_bit_clr = 1'b1;
          w_nstate  = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) w_nstate = S_STOP;
        end
      end
      S_STOP: begin
        if (w_last) begin
          if (w_rx_s) begin
            w_push   = 1'b1;
            w_nstate = S_IDLE;
          end else begin
            w_ferr   = 1'b1;
            w_nstate = S_HUNT;
          end
        end
      end
      default: w_nstate = S_HUNT;
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= (w_cnt_clr || w_last) ? '0 : r_cnt + 1'b1;
      if (w_bit_clr)       r_bit <= '0;
      else if (w_shift_en) r_bit <= r_bit + 1'b1;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[7:1]};
    end
  end

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = !w_empty && rx_ready;
  // When the FIFO is full, a pop in the same cycle frees the head slot. The
  // write lands in that slot while the read pointer moves past it.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr[AW-1:0]] <= r_shift;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  // One-cycle status pulses, registered after the stop-bit sample edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overflow  <= w_drop;
    end
  end

  assign rx_data      = r_mem[r_rd[AW-1:0]];
  assign rx_valid     = !w_empty;
  assign rx_frame_err = r_frame_err;
  assign rx_overflow  = r_overflow;
  assign rx_busy      = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_STOP);

endmodule

// File: tb/tb_uartprobe_rx.sv
// Testbench for uartprobe_rx: directed scenarios plus a randomized frame stream
// checked against a queue-based byte model.
module tb_uartprobe_rx;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int H     = CPB / 2;
  localparam int BUSY  = H + 9 * CPB;  // k=0 up to the stop sample

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_overflow, rx_busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Monitor state: only the monitor process writes these.
  logic [7:0] got_q[$];
  int         got_t[$];
  int         n_ferr = 0, n_ovf = 0, n_busy = 0, n_valid = 0;
  int         clr_req = 0, clr_seen = 0;

  logic [7:0] exp_q[$];

  uartprobe_rx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .aresetn(aresetn), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (clr_seen != clr_req) begin
      got_q.delete(); got_t.delete();
      n_ferr = 0; n_ovf = 0; n_busy = 0; n_valid = 0;
      clr_seen = clr_req;
    end
    if (aresetn) begin
      if (rx_valid && rx_ready) begin
        got_q.push_back(rx_data);
        got_t.push_back(cyc);
      end
      if (rx_frame_err) n_ferr++;
      if (rx_overflow)  n_ovf++;
      if (rx_busy)      n_busy++;
      if (rx_valid)     n_valid++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    clr_req++;
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    tick(CPB);
  endtask

  // Line is left at the stop-bit level when this returns.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    aresetn = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0;
    tick(3);
    n_chk++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %0h want 0", rx_data); end
    n_chk++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", rx_valid); end
    n_chk++; if (rx_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %0b want 0", rx_frame_err); end
    n_chk++; if (rx_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", rx_overflow); end
    n_chk++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", rx_busy); end
    aresetn = 1'b1;
    tick(4);
    n_chk++; if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin n_err++; $display("FAIL post_reset got valid %0b busy %0b want 0 0", rx_valid, rx_busy); end
  endtask

  task automatic test_single_byte();
    rx_ready = 1'b1;
    clear_mon(); tick(2);
    send_frame(8'hA5, 1'b1);
    tick(6);
    n_chk++; if (got_q.size() != 1) begin n_err++; $display("FAIL single_count got %0d want 1", got_q.size()); end
    else begin
      n_chk++; if (got_q[0] !== 8'hA5) begin n_err++; $display("FAIL single_data got %0h want a5", got_q[0]); end
    end
    n_chk++; if (n_valid != 1) begin n_err++; $display("FAIL single_valid_cycles got %0d want 1", n_valid); end
    n_chk++; if (n_busy != BUSY) begin n_err++; $display("FAIL single_busy_cycles got %0d want %0d", n_busy, BUSY); end
    n_chk++; if (n_ferr != 0 || n_ovf != 0) begin n_err++; $display("FAIL single_errs got ferr %0d ovf %0d want 0 0", n_ferr, n_ovf); end
  endtask

  task automatic test_glitch();
    rx_ready = 1'b1;
    clear_mon(); tick(2);
    uart_rx = 1'b0; tick(3);
    uart_rx = 1'b1; tick(12);
    n_chk++; if (n_valid != 0) begin n_err++; $display("FAIL glitch_valid got %0d want 0", n_valid); end
    n_chk++; if (n_ferr != 0) begin n_err++; $display("FAIL glitch_ferr got %0d want 0", n_ferr); end
    n_chk++; if (n_busy != H) begin n_err++; $display("FAIL glitch_busy_cycles got %0d want %0d", n_busy, H); end
    clear_mon(); tick(1);
    send_frame(8'h5A, 1'b1);
    tick(4);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin n_err++; $display("FAIL glitch_next got n=%0d want 1 byte 5a", got_q.size()); end
  endtask

  task automatic test_frame_err();
    rx_ready = 1'b1;
    clear_mon(); tick(2);
    send_frame(8'h3C, 1'b0);
    tick(20);              // line still low: break condition
    uart_rx = 1'b1; tick(10);
    send_frame(8'h11, 1'b1);
    tick(4);
    n_chk++; if (n_ferr != 1) begin n_err++; $display("FAIL ferr_pulses got %0d want 1", n_ferr); end
    n_chk++; if (got_q.size() != 1) begin n_err++; $display("FAIL ferr_count got %0d want 1", got_q.size()); end
    else begin
      n_chk++; if (got_q[0] !== 8'h11) begin n_err++; $display("FAIL ferr_next got %0h want 11", got_q[0]); end
    end
    n_chk++; if (n_ovf != 0) begin n_err++; $display("FAIL ferr_ovf got %0d want 0", n_ovf); end
  endtask

  task automatic test_overflow();
    int exp_ovf;
    rx_ready = 1'b0;
    clear_mon(); tick(2);
    exp_q.delete(); exp_ovf = 0;
    for (int d = 1; d <= 5; d++) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(d));
      else exp_ovf++;
      send_frame(8'(d), 1'b1);
    end
    tick(4);
    n_chk++; if (n_ovf != exp_ovf) begin n_err++; $display("FAIL ovf_pulses got %0d want %0d", n_ovf, exp_ovf); end
    n_chk++; if (got_q.size() != 0 || rx_valid !== 1'b1) begin n_err++; $display("FAIL ovf_hold got n=%0d valid %0b want 0 1", got_q.size(), rx_valid); end
    rx_ready = 1'b1;
    tick(DEPTH + 3);
    rx_ready = 1'b0;
    n_chk++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_drain_count got %0d want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_drain_%0d got %0h want %0h", i, got_q[i], exp_q[i]); end
        n_chk++; if (got_t[i] != got_t[0] + i) begin n_err++; $display("FAIL ovf_drain_cycle_%0d got %0d want %0d", i, got_t[i], got_t[0] + i); end
      end
    end
    n_chk++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got valid %0b want 0", rx_valid); end
  endtask

  task automatic test_full_pop();
    logic [7:0] want[$];
    rx_ready = 1'b0;
    clear_mon(); tick(2);
    exp_q.delete(); want.delete();
    for (int d = 'h10; d <= 'h13; d++) begin
      exp_q.push_back(8'(d));
      send_frame(8'(d), 1'b1);
    end
    // The pop coinciding with the stop sample removes the head, and the new byte joins the tail.
    want.push_back(exp_q.pop_front());
    exp_q.push_back(8'h14);
    fork
      send_frame(8'h14, 1'b1);
      begin
        // Stop sample lands 2 sync edges + 1 detect edge + H + 9 bits after the pin falls.
        tick(2 + H + 9 * CPB);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(2);
    n_chk++; if (n_ovf != 0) begin n_err++; $display("FAIL fullpop_ovf got %0d want 0", n_ovf); end
    rx_ready = 1'b1;
    tick(DEPTH + 3);
    rx_ready = 1'b0;
    while (exp_q.size() > 0) want.push_back(exp_q.pop_front());
    n_chk++; if (got_q.size() != want.size()) begin n_err++; $display("FAIL fullpop_count got %0d want %0d", got_q.size(), want.size()); end
    else begin
      for (int i = 0; i < want.size(); i++) begin
        n_chk++; if (got_q[i] !== want[i]) begin n_err++; $display("FAIL fullpop_%0d got %0h want %0h", i, got_q[i], want[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    rx_ready = 1'b0;
    clear_mon(); tick(2);
    send_frame(8'h22, 1'b1);
    tick(2);
    n_chk++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_buffered got valid %0b want 1", rx_valid); end
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    uart_rx = 1'b1; tick(H);   // midway through data bit 4
    aresetn = 1'b0;
    #1;
    n_chk++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_fifo got valid %0b data %0h want 0 0", rx_valid, rx_data); end
    n_chk++; if (rx_busy !== 1'b0 || rx_frame_err !== 1'b0 || rx_overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_outs got busy %0b ferr %0b ovf %0b want 0 0 0", rx_busy, rx_frame_err, rx_overflow); end
    tick(2);
    uart_rx = 1'b0;
    aresetn = 1'b1;
    clear_mon();
    tick(H + 10 * CPB + 8);    // line low long enough for any false frame to end
    uart_rx = 1'b1; tick(10);
    n_chk++; if (n_valid != 0) begin n_err++; $display("FAIL rstmid_nobyte got %0d valid cycles want 0", n_valid); end
    rx_ready = 1'b1;
    clear_mon(); tick(1);
    send_frame(8'h77, 1'b1);
    tick(4);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 8'h77) begin n_err++; $display("FAIL rstmid_next got n=%0d want 1 byte 77", got_q.size()); end
  endtask

  task automatic test_random();
    int exp_ferr;
    bit done;
    exp_q.delete(); exp_ferr = 0; done = 1'b0;
    uart_rx = 1'b1;
    clear_mon(); tick(2);
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [7:0] d;
          logic       stop;
          if ($urandom_range(0, 4) == 0) begin
            uart_rx = 1'b0; tick($urandom_range(1, 3));
            uart_rx = 1'b1; tick(CPB);
          end
          d    = 8'($urandom_range(0, 255));
          stop = ($urandom_range(0, 4) != 0);
          send_frame(d, stop);
          if (stop) exp_q.push_back(d);
          else exp_ferr++;
          uart_rx = 1'b1;
          tick($urandom_range(4, 12));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rx_ready = 1'b1;
    tick(DEPTH + 3);
    n_chk++; if (n_ferr != exp_ferr) begin n_err++; $display("FAIL rand_ferr got %0d want %0d", n_ferr, exp_ferr); end
    n_chk++; if (n_ovf != 0) begin n_err++; $display("FAIL rand_ovf got %0d want 0", n_ovf); end
    n_chk++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_byte_%0d got %0h want %0h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uartprobe_rx.md
# uartprobe_rx

UART receive front end for the probe. Recovers 8N1 bytes from the asynchronous `uart_rx` pin, checks framing, and buffers the bytes in a small FIFO. The probe's command decoder consumes them over a valid/ready byte stream. The block sits directly between the board pin and the uartprobe command path.

## Interface
- `CYCLES_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 4.
- `FIFO_DEPTH`, default 4: number of receive buffer entries. Must be a power of 2, ≥ 2.
- `clk` in 1: single clock; all logic is on its rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `uart_rx` in 1: serial line; idle high; asynchronous to `clk`.
- `rx_data` out 8: byte at the FIFO head. Reset value 0x00.
- `rx_valid` out 1: FIFO non-empty. Reset value 0.
- `rx_ready` in 1: consumer accepts `rx_data` this cycle.
- `rx_frame_err` out 1: one-cycle pulse when a stop bit is sampled low. Reset value 0.
- `rx_overflow` out 1: one-cycle pulse when a received byte is dropped because the FIFO is full. Reset value 0.
- `rx_busy` out 1: high in START, DATA and STOP states. Reset value 0.

## Operation
- **Synchronizer:** two flops, both reset to 1; `rx_s` is the second flop.
- **Bit counter:** counts 0 to `CYCLES_PER_BIT`-1. Let `H` = `CYCLES_PER_BIT`/2 (integer division).
- **FSM states:** HUNT, IDLE, START, DATA, STOP. Reset state is HUNT.
  - **HUNT:** wait for `rx_s`=1, then go to IDLE. This prevents mid-frame or break garbage from being taken as a start bit.
  - **IDLE:** `rx_s`=0 moves to START and clears the counter. Call this edge k=0.
  - **START:** at k=H, sample `rx_s`.
    - If `rx_s`=1 (glitch): go to IDLE. No output, no error.
    - Otherwise: go to DATA with bit index 0.
  - **DATA:** sample at k = H + n·`CYCLES_PER_BIT`, for n=1..8. Shift bits in LSB first. After n=8, go to STOP.
  - **STOP:** sample at k = H + 9·`CYCLES_PER_BIT`.
    - If the sample is 1: push the byte to the FIFO, go to IDLE.
    - If the sample is 0: pulse `rx_frame_err`, discard the byte, go to HUNT.
- **FIFO:** circular buffer with `FIFO_DEPTH` entries and pointers one bit wider than the index.
  - `rx_data` and `rx_valid` are driven from the head entry and are registered-stable.
  - A pop occurs when `rx_valid` && `rx_ready`.
  - Push while full with no pop in the same cycle: the byte is dropped and `rx_overflow` pulses. FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, no overflow.
  - Push and pop in the same cycle while empty: the push takes effect, nothing is popped.
- **Reset:** async assertion at any time, including mid-frame, returns the FSM to HUNT, empties the FIFO, and drives all outputs to their reset values.

## Timing
- Pin to `rx_s`: 2 cycles.
- Byte is written at edge k = H + 9·`CYCLES_PER_BIT`. `rx_valid` is high after that edge (1 cycle). A full frame is counted from k=0.
- `rx_frame_err` and `rx_overflow` are asserted for exactly the one cycle after the stop-bit sample edge.
- `rx_busy` rises the cycle after k=0. It falls the cycle after the stop-bit sample or the glitch rejection.
- **Back-to-back frames:** a start bit arriving immediately after the stop-bit sample point (half a bit later) is detected. IDLE is entered the cycle after the stop sample.
- **Drain rate:** one byte per cycle while `rx_ready`=1.

## Test plan
All directed tests use `CYCLES_PER_BIT`=8 and `FIFO_DEPTH`=4.
- **Single byte:** drive frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) with `rx_ready`=1. Required: one-cycle `rx_valid` with `rx_data`=0xA5. `rx_frame_err`=0 and `rx_overflow`=0 throughout. `rx_busy` high for exactly the frame span.
- **Glitch rejection:** drive a 3-cycle low pulse on `uart_rx`. Required: `rx_valid` stays 0 and no error pulse. The FSM returns to IDLE, and a following 0x5A frame is received correctly.
- **Framing error:** drive 0x3C with the stop bit low, then hold the line low for 20 cycles, then high, then send 0x11. Required: one `rx_frame_err` pulse, no byte for 0x3C, no spurious byte during the low hold. 0x11 is received.
- **Overflow:** with `rx_ready`=0, send 0x01..0x05 back-to-back. Required: a single `rx_overflow` pulse on the 5th frame. Then with `rx_ready`=1, the bytes drain in order 0x01, 0x02, 0x03, 0x04 on consecutive cycles, and `rx_valid` then drops.
- **Full with simultaneous pop:** fill the FIFO with 0x10..0x13. Assert `rx_ready` for one cycle coinciding with the stop sample of 0x14. Required: no overflow, and the drain order is 0x11, 0x12, 0x13, 0x14.
- **Reset mid-frame:** assert `aresetn`=0 during data bit 4 of 0xFF, with one byte already buffered. Required: all outputs read 0 immediately and the FIFO is empty. After release, with the line low for the remaining bits, no byte is produced. The next clean frame 0x77 is received.
